// File: rtl/id_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// id_fetch_ctrl_if
// Bundle between the decode-side fetch controller and its neighbours: the
// fetch stage, the register file and the EX stage.
//
//   Fetch -> ID   : if_pc, if_instr
//   ID -> Fetch   : stall_if, branch_taken, branch_target
//   ID <-> RegFile: rs1_addr, rs2_addr (out), rs1_data, rs2_data (in)
//   EX -> ID      : ex_mem_read, ex_reg_write, ex_rd, ex_stall
//   ID -> EX      : id_pc, id_instr, id_issue
//   Perf          : perf_branch_cnt, perf_stall_cnt
//
// Modports: slave  = the id_fetch_ctrl block itself
//           master = the surrounding pipeline (or a testbench)
// ---------------------------------------------------------------------------
interface id_fetch_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int PERF_W = 16
);
    logic [DATA_W-1:0] if_pc;
    logic [DATA_W-1:0] if_instr;
    logic              stall_if;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
    logic [3:0]        rs1_addr;
    logic [3:0]        rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              ex_mem_read;
    logic              ex_reg_write;
    logic [3:0]        ex_rd;
    logic              ex_stall;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_instr;
    logic              id_issue;
    logic [PERF_W-1:0] perf_branch_cnt;
    logic [PERF_W-1:0] perf_stall_cnt;

    modport slave (
        input  if_pc, if_instr, rs1_data, rs2_data,
               ex_mem_read, ex_reg_write, ex_rd, ex_stall,
        output stall_if, branch_taken, branch_target, rs1_addr, rs2_addr,
               id_pc, id_instr, id_issue, perf_branch_cnt, perf_stall_cnt
    );

    modport master (
        output if_pc, if_instr, rs1_data, rs2_data,
               ex_mem_read, ex_reg_write, ex_rd, ex_stall,
        input  stall_if, branch_taken, branch_target, rs1_addr, rs2_addr,
               id_pc, id_instr, id_issue, perf_branch_cnt, perf_stall_cnt
    );
endinterface

// File: rtl/id_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// id_fetch_ctrl
// Decode-side counterpart of the fetch stage. Holds the IF/ID pipeline
// register, resolves branches/jumps in ID, detects operand hazards against
// the instruction in EX, and tells fetch to hold or redirect.
//
// Ports:
//   clk  - system clock, all state changes on posedge
//   rst  - asynchronous reset, active-low
//   bus  - id_fetch_ctrl_if.slave (fetch, regfile, EX and perf signals)
//
// Instruction format: op = [15:12]. Ops 9/C/D/F carry rs1=[11:8], rs2=[7:4];
// all others rs1=[7:4], rs2=[3:0]. C=BEQ, D=BNE, E=JMP, F=JR.
//
// stall_if, branch_taken and branch_target are combinational on purpose:
// fetch needs them in the same cycle the ID instruction is evaluated.
// ---------------------------------------------------------------------------
module id_fetch_ctrl #(
    parameter int DATA_W = 16,
    parameter int PERF_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    id_fetch_ctrl_if.slave  bus
);

    localparam logic [3:0]        OP_BEQ   = 4'hC;
    localparam logic [3:0]        OP_BNE   = 4'hD;
    localparam logic [3:0]        OP_JMP   = 4'hE;
    localparam logic [3:0]        OP_JR    = 4'hF;
    localparam logic [3:0]        REG_ZERO = 4'h0;
    localparam logic [DATA_W-1:0] NOP      = {DATA_W{1'b0}};
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    // IF/ID pipeline state and performance counters
    logic              id_valid_r;
    logic [DATA_W-1:0] id_pc_r;
    logic [DATA_W-1:0] id_instr_r;
    logic [PERF_W-1:0] perf_branch_cnt_r;
    logic [PERF_W-1:0] perf_stall_cnt_r;

    // Decode results
    logic [3:0]        op_s;
    logic              wide_fmt_s;
    logic              uses_rs1_s;
    logic              uses_rs2_s;
    logic              resolves_in_id_s;
    logic [3:0]        rs1_s;
    logic [3:0]        rs2_s;

    // Hazard / issue control
    logic              match1_s;
    logic              match2_s;
    logic              dep_s;
    logic              hazard_s;
    logic              stall_s;
    logic              go_s;

    // Redirect
    logic [DATA_W-1:0] off_br_s;
    logic [DATA_W-1:0] off_jmp_s;
    logic              cond_s;
    logic [DATA_W-1:0] target_raw_s;
    logic              taken_s;
    logic [DATA_W-1:0] target_s;

    // Field decode of the instruction held in ID
    always_comb begin
        op_s             = id_instr_r[15:12];
        wide_fmt_s       = 1'b0;
        uses_rs2_s       = 1'b0;
        resolves_in_id_s = 1'b0;
        case (op_s)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: begin
                uses_rs2_s = 1'b1;
            end
            4'h9: begin
                wide_fmt_s = 1'b1;
                uses_rs2_s = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                wide_fmt_s       = 1'b1;
                uses_rs2_s       = 1'b1;
                resolves_in_id_s = 1'b1;
            end
            OP_JR: begin
                wide_fmt_s       = 1'b1;
                resolves_in_id_s = 1'b1;
            end
            default: begin
                wide_fmt_s       = 1'b0;
                uses_rs2_s       = 1'b0;
                resolves_in_id_s = 1'b0;
            end
        endcase
        uses_rs1_s = (op_s != OP_JMP);
        if (wide_fmt_s) begin
            rs1_s = id_instr_r[11:8];
            rs2_s = id_instr_r[7:4];
        end else begin
            rs1_s = id_instr_r[7:4];
            rs2_s = id_instr_r[3:0];
        end
    end

    // Hazard detection against EX and the issue/stall decision
    always_comb begin
        match1_s = uses_rs1_s & (bus.ex_rd == rs1_s);
        match2_s = uses_rs2_s & (bus.ex_rd == rs2_s);
        // r0 is hard-wired, so a write to it can never feed an operand
        dep_s    = (bus.ex_rd != REG_ZERO) & (match1_s | match2_s);
        // Loads always need a bubble; ALU results only matter to ops that
        // compare or jump in ID, because the EX->ID path has no bypass.
        hazard_s = id_valid_r & dep_s &
                   (bus.ex_mem_read | (bus.ex_reg_write & resolves_in_id_s));
        stall_s  = id_valid_r & (hazard_s | bus.ex_stall);
        go_s     = id_valid_r & ~hazard_s & ~bus.ex_stall;
    end

    // Branch/jump resolution; only an issuing instruction may redirect
    always_comb begin
        off_br_s     = {{(DATA_W-4){id_instr_r[3]}}, id_instr_r[3:0]};
        off_jmp_s    = {{(DATA_W-12){id_instr_r[11]}}, id_instr_r[11:0]};
        cond_s       = 1'b0;
        target_raw_s = NOP;
        case (op_s)
            OP_BEQ: begin
                cond_s       = (bus.rs1_data == bus.rs2_data);
                target_raw_s = id_pc_r + off_br_s;
            end
            OP_BNE: begin
                cond_s       = (bus.rs1_data != bus.rs2_data);
                target_raw_s = id_pc_r + off_br_s;
            end
            OP_JMP: begin
                cond_s       = 1'b1;
                target_raw_s = id_pc_r + off_jmp_s;
            end
            OP_JR: begin
                cond_s       = 1'b1;
                target_raw_s = bus.rs1_data;
            end
            default: begin
                cond_s       = 1'b0;
                target_raw_s = NOP;
            end
        endcase
        if (go_s) begin
            taken_s = cond_s;
        end else begin
            taken_s = 1'b0;
        end
        if (taken_s) begin
            target_s = target_raw_s;
        end else begin
            target_s = NOP;
        end
    end

    // IF/ID pipeline register: hold on stall, squash on redirect, else load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_r <= 1'b0;
            id_pc_r    <= NOP;
            id_instr_r <= NOP;
        end else if (stall_s) begin
            id_valid_r <= id_valid_r;
            id_pc_r    <= id_pc_r;
            id_instr_r <= id_instr_r;
        end else if (taken_s) begin
            // if_instr is the wrong-path fall-through: drop it
            id_valid_r <= 1'b0;
            id_pc_r    <= id_pc_r;
            id_instr_r <= NOP;
        end else begin
            id_valid_r <= 1'b1;
            id_pc_r    <= bus.if_pc;
            id_instr_r <= bus.if_instr;
        end
    end

    // Saturating performance counters for redirects and stall cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_branch_cnt_r <= {PERF_W{1'b0}};
            perf_stall_cnt_r  <= {PERF_W{1'b0}};
        end else begin
            if (taken_s && (perf_branch_cnt_r != PERF_MAX)) begin
                perf_branch_cnt_r <= perf_branch_cnt_r + PERF_ONE;
            end
            if (stall_s && (perf_stall_cnt_r != PERF_MAX)) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + PERF_ONE;
            end
        end
    end

    assign bus.stall_if        = stall_s;
    assign bus.branch_taken    = taken_s;
    assign bus.branch_target   = target_s;
    assign bus.rs1_addr        = rs1_s;
    assign bus.rs2_addr        = rs2_s;
    assign bus.id_pc           = id_pc_r;
    assign bus.id_instr        = id_instr_r;
    assign bus.id_issue        = go_s;
    assign bus.perf_branch_cnt = perf_branch_cnt_r;
    assign bus.perf_stall_cnt  = perf_stall_cnt_r;

endmodule

// File: tb/tb_id_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_fetch_ctrl
// Directed stimulus for id_fetch_ctrl. A behavioural model (pipeline slot as
// plain variables, counters as integers) is checked against the DUT on every
// falling clock edge; literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_id_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    id_fetch_ctrl_if #(.DATA_W(16), .PERF_W(16)) bus ();

    id_fetch_ctrl #(.DATA_W(16), .PERF_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic        m_valid    = 1'b0;
    logic [15:0] m_pc       = 16'h0000;
    logic [15:0] m_instr    = 16'h0000;
    logic        m_pc_known = 1'b1;
    int          m_bcnt     = 0;
    int          m_scnt     = 0;
    logic        sat_req    = 1'b0;
    logic        sat_done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    // Model: compute what the outputs must be, compare, then advance one cycle
    always @(negedge clk) begin : model_cmp
        logic [3:0] op, r1, r2;
        logic       wide, u1, u2, dep, haz, stall, go, taken;
        int         tgt;
        if (!rst) begin
            m_valid = 1'b0; m_pc = 16'h0000; m_instr = 16'h0000;
            m_pc_known = 1'b1; m_bcnt = 0; m_scnt = 0;
        end
        if (sat_req && !sat_done) begin
            m_bcnt   = 65535;
            sat_done = 1'b1;
        end
        op    = m_instr[15:12];
        wide  = op inside {4'h9, 4'hC, 4'hD, 4'hF};
        r1    = wide ? m_instr[11:8] : m_instr[7:4];
        r2    = wide ? m_instr[7:4]  : m_instr[3:0];
        u1    = (op != 4'hE);
        u2    = op inside {[4'h0:4'h7], 4'h9, 4'hC, 4'hD};
        dep   = (bus.ex_rd != 4'h0) && ((u1 && bus.ex_rd == r1) || (u2 && bus.ex_rd == r2));
        haz   = m_valid && dep &&
                (bus.ex_mem_read || (bus.ex_reg_write && (op inside {4'hC, 4'hD, 4'hF})));
        stall = m_valid && (haz || bus.ex_stall);
        go    = m_valid && !haz && !bus.ex_stall;
        taken = 1'b0;
        tgt   = 0;
        if (go) begin
            if (op == 4'hC && bus.rs1_data == bus.rs2_data) begin
                taken = 1'b1; tgt = (int'(m_pc) + sext(int'(m_instr[3:0]), 4)) & 32'hFFFF;
            end else if (op == 4'hD && bus.rs1_data != bus.rs2_data) begin
                taken = 1'b1; tgt = (int'(m_pc) + sext(int'(m_instr[3:0]), 4)) & 32'hFFFF;
            end else if (op == 4'hE) begin
                taken = 1'b1; tgt = (int'(m_pc) + sext(int'(m_instr[11:0]), 12)) & 32'hFFFF;
            end else if (op == 4'hF) begin
                taken = 1'b1; tgt = int'(bus.rs1_data);
            end
        end
        check("m_stall_if", bus.stall_if, stall);
        check("m_branch_taken", bus.branch_taken, taken);
        check("m_branch_target", bus.branch_target, tgt);
        check("m_rs1_addr", bus.rs1_addr, r1);
        check("m_rs2_addr", bus.rs2_addr, r2);
        check("m_id_issue", bus.id_issue, go);
        check("m_id_instr", bus.id_instr, m_instr);
        if (m_pc_known) check("m_id_pc", bus.id_pc, m_pc);
        check("m_perf_branch", bus.perf_branch_cnt, m_bcnt);
        check("m_perf_stall", bus.perf_stall_cnt, m_scnt);
        if (rst) begin
            if (taken && m_bcnt < 65535) m_bcnt++;
            if (stall && m_scnt < 65535) m_scnt++;
            if (stall) begin
                // slot held
            end else if (taken) begin
                m_valid = 1'b0; m_instr = 16'h0000; m_pc_known = 1'b0;
            end else begin
                m_valid = 1'b1; m_pc = bus.if_pc; m_instr = bus.if_instr; m_pc_known = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] instr);
        bus.if_pc    = pc;
        bus.if_instr = instr;
    endtask

    initial begin
        bus.if_pc = 16'h0000; bus.if_instr = 16'h0000;
        bus.rs1_data = 16'h0000; bus.rs2_data = 16'h0000;
        bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_rd = 4'h0; bus.ex_stall = 1'b0;

        // reset state
        #1 rst = 1'b0;
        #2;
        check("rst_issue", bus.id_issue, 32'd0);
        check("rst_stall", bus.stall_if, 32'd0);
        check("rst_id_pc", bus.id_pc, 32'd0);
        check("rst_id_instr", bus.id_instr, 32'd0);
        check("rst_perf_branch", bus.perf_branch_cnt, 32'd0);
        tick(); tick();
        rst = 1'b1;

        // straight-line flow
        fetch(16'h0000, 16'h1234); tick();
        fetch(16'h0001, 16'h2345); #1;
        check("sl_instr0", bus.id_instr, 32'h1234);
        check("sl_issue0", bus.id_issue, 32'd1);
        check("sl_stall0", bus.stall_if, 32'd0);
        tick();
        fetch(16'h0002, 16'h0134); #1;
        check("sl_instr1", bus.id_instr, 32'h2345);
        check("sl_issue1", bus.id_issue, 32'd1);
        tick();

        // load-use on r3
        bus.ex_mem_read = 1'b1; bus.ex_rd = 4'h3;
        fetch(16'h0003, 16'h0000); #1;
        check("lu_stall", bus.stall_if, 32'd1);
        check("lu_issue", bus.id_issue, 32'd0);
        check("lu_cnt0", bus.perf_stall_cnt, 32'd0);
        tick();
        // EX now holds an ALU writer of r3: no hazard for a non-branch
        bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b1; #1;
        check("lu_hold_instr", bus.id_instr, 32'h0134);
        check("lu_hold_pc", bus.id_pc, 32'h0002);
        check("lu_cnt1", bus.perf_stall_cnt, 32'd1);
        check("alu_nostall", bus.stall_if, 32'd0);
        check("alu_issue", bus.id_issue, 32'd1);
        tick();
        bus.ex_reg_write = 1'b0; bus.ex_rd = 4'h0;

        // BEQ taken, then squash, then BEQ not taken
        fetch(16'h0010, 16'hC12F); tick();
        fetch(16'h0011, 16'h1111); bus.rs1_data = 16'h0005; bus.rs2_data = 16'h0005; #1;
        check("beq_taken", bus.branch_taken, 32'd1);
        check("beq_target", bus.branch_target, 32'h000F);
        check("beq_stall", bus.stall_if, 32'd0);
        check("beq_rs1", bus.rs1_addr, 32'h1);
        check("beq_rs2", bus.rs2_addr, 32'h2);
        tick();
        fetch(16'h0010, 16'hC12F); #1;
        check("sq_issue", bus.id_issue, 32'd0);
        check("sq_instr", bus.id_instr, 32'h0000);
        check("sq_taken", bus.branch_taken, 32'd0);
        check("sq_perf_branch", bus.perf_branch_cnt, 32'd1);
        tick();
        bus.rs2_data = 16'h0006;
        fetch(16'h0005, 16'hE800); #1;
        check("beq_nt_taken", bus.branch_taken, 32'd0);
        check("beq_nt_target", bus.branch_target, 32'h0000);
        check("beq_nt_issue", bus.id_issue, 32'd1);
        tick();

        // JMP with wrap, then JR
        fetch(16'h0006, 16'h1111); #1;
        check("jmp_taken", bus.branch_taken, 32'd1);
        check("jmp_target", bus.branch_target, 32'hF805);
        tick();
        fetch(16'h0006, 16'hF200); tick();
        bus.rs1_data = 16'hABCD;
        fetch(16'h0007, 16'h0000); #1;
        check("jr_target", bus.branch_target, 32'hABCD);
        check("jr_rs1", bus.rs1_addr, 32'h2);
        tick();

        // BNE on r4 while EX writes r4: stall one cycle, then resolve
        fetch(16'h0020, 16'hD450); tick();
        bus.ex_reg_write = 1'b1; bus.ex_rd = 4'h4;
        bus.rs1_data = 16'h0007; bus.rs2_data = 16'h0007;
        fetch(16'h0021, 16'h0000); #1;
        check("bh_stall", bus.stall_if, 32'd1);
        check("bh_taken", bus.branch_taken, 32'd0);
        check("bh_issue", bus.id_issue, 32'd0);
        tick();
        bus.ex_reg_write = 1'b0; bus.ex_rd = 4'h0; bus.rs1_data = 16'h0008; #1;
        check("bh_res_taken", bus.branch_taken, 32'd1);
        check("bh_res_target", bus.branch_target, 32'h0020);
        check("bh_res_stall", bus.stall_if, 32'd0);
        tick();
        fetch(16'h0020, 16'hD450); tick();
        // writer to r0 never stalls
        bus.ex_reg_write = 1'b1; bus.ex_rd = 4'h0;
        bus.rs1_data = 16'h0009; bus.rs2_data = 16'h0009; #1;
        check("r0_stall", bus.stall_if, 32'd0);
        check("r0_issue", bus.id_issue, 32'd1);
        tick();

        // EX backpressure
        bus.ex_reg_write = 1'b0; bus.ex_stall = 1'b1;
        fetch(16'h0021, 16'h1234); #1;
        check("exs_stall", bus.stall_if, 32'd1);
        check("exs_issue", bus.id_issue, 32'd0);
        tick();
        bus.ex_stall = 1'b0; tick();
        fetch(16'h0030, 16'hE001); tick();

        // counter saturation on a JMP
        force dut.perf_branch_cnt_r = 16'hFFFF;
        sat_req = 1'b1;
        #1 release dut.perf_branch_cnt_r;
        check("sat_jmp_taken", bus.branch_taken, 32'd1);
        check("sat_jmp_target", bus.branch_target, 32'h0031);
        fetch(16'h0031, 16'h0000); tick();
        // a bubble ignores backpressure
        bus.ex_stall = 1'b1; #1;
        check("sat_perf_branch", bus.perf_branch_cnt, 32'hFFFF);
        check("bub_stall", bus.stall_if, 32'd0);
        check("bub_issue", bus.id_issue, 32'd0);
        bus.ex_stall = 1'b0;
        tick();

        // asynchronous reset in the middle of a stall
        fetch(16'h0040, 16'h0134); tick();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 4'h3; #1;
        check("mr_pre_stall", bus.stall_if, 32'd1);
        rst = 1'b0; #1;
        check("mr_stall", bus.stall_if, 32'd0);
        check("mr_taken", bus.branch_taken, 32'd0);
        check("mr_target", bus.branch_target, 32'd0);
        check("mr_issue", bus.id_issue, 32'd0);
        check("mr_id_pc", bus.id_pc, 32'd0);
        check("mr_id_instr", bus.id_instr, 32'd0);
        check("mr_perf_branch", bus.perf_branch_cnt, 32'd0);
        check("mr_perf_stall", bus.perf_stall_cnt, 32'd0);
        check("mr_rs1", bus.rs1_addr, 32'd0);
        check("mr_rs2", bus.rs2_addr, 32'd0);
        tick();
        bus.ex_mem_read = 1'b0; bus.ex_rd = 4'h0;
        rst = 1'b1;
        fetch(16'h0041, 16'h2345); tick();
        #1;
        check("post_instr", bus.id_instr, 32'h2345);
        check("post_pc", bus.id_pc, 32'h0041);
        check("post_issue", bus.id_issue, 32'd1);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
